// File: rtl/flash_programmer_if.sv
// Client handshake plus flash pin bundle for flash_programmer.
// slave = the programmer; master = the client and the top-level pin mux.
interface flash_programmer_if;
    logic [22:0] iSTART_ADDR;
    logic        iLOAD;
    logic        iCHIP_ERASE;
    logic [31:0] iDATA;
    logic        iVALID;
    logic        oREADY;
    logic        oBUSY;
    logic        oERR;
    logic [22:0] oADDR;
    logic [7:0]  oDQ;
    logic        oDQ_OE;
    logic [7:0]  iDQ;
    logic        oCE_N;
    logic        oOE_N;
    logic        oWE_N;
    logic        iRY;

    modport slave (
        input  iSTART_ADDR, iLOAD, iCHIP_ERASE, iDATA, iVALID, iDQ, iRY,
        output oREADY, oBUSY, oERR, oADDR, oDQ, oDQ_OE, oCE_N, oOE_N, oWE_N
    );

    modport master (
        output iSTART_ADDR, iLOAD, iCHIP_ERASE, iDATA, iVALID, iDQ, iRY,
        input  oREADY, oBUSY, oERR, oADDR, oDQ, oDQ_OE, oCE_N, oOE_N, oWE_N
    );
endinterface

// File: rtl/flash_programmer.sv
// Programs 32-bit words byte by byte (unlock/A0 sequence) into CFI byte-mode flash, plus chip erase.
// Latency: 4 bus writes of WE_LOW_CYC+3 cycles, BUSY_DLY_CYC, then RY/BY# poll per byte; FLASH_PROG_VERIFY_EN adds a read-back.
// Backpressure: oREADY only in IDLE with no load/erase pending; one word in flight at a time.
module flash_programmer #(
    parameter int WE_LOW_CYC   = 1,
    parameter int BUSY_DLY_CYC = 2,
    parameter int TIMEOUT_CYC  = 4000,
    parameter int RD_CYC       = 2
) (
    input logic               iCLK,
    input logic               iRSTN,
    flash_programmer_if.slave bus
);
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CMD, S_BUS_SETUP, S_BUS_WE, S_BUS_HOLD,
        S_WAIT_BUSY, S_WAIT_RDY, S_NEXT, S_ERROR
`ifdef FLASH_PROG_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    typedef enum logic [1:0] {M_PROG, M_ERASE, M_RST} mode_t;

    state_t            state, state_nxt;
    mode_t             mode, mode_nxt;
    logic [22:0]       addr, addr_nxt;
    logic [31:0]       word, word_nxt;
    logic [1:0]        idx, idx_nxt;
    logic [2:0]        step, step_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              err, err_nxt;
    logic [22:0]       bus_addr, bus_addr_nxt;
    logic [7:0]        bus_dat, bus_dat_nxt;
    logic              rst_done;

    logic [7:0]        cur_byte;
    logic [22:0]       cmd_addr;
    logic [7:0]        cmd_dat;
    logic [2:0]        last_step;
    logic              rdy, ce_n, we_n, oe_n, dq_oe;

    assign cur_byte = word[{idx, 3'b000} +: 8];

    // Command table: address/data of the current step for the active sequence.
    always_comb begin
        cmd_addr  = 23'hAAA;
        cmd_dat   = 8'hAA;
        last_step = 3'd0;
        case (mode)
            M_PROG: begin
                last_step = 3'd3;
                case (step)
                    3'd0:    cmd_dat = 8'hAA;
                    3'd1:    begin cmd_addr = 23'h555; cmd_dat = 8'h55; end
                    3'd2:    cmd_dat = 8'hA0;
                    default: begin cmd_addr = addr; cmd_dat = cur_byte; end
                endcase
            end
            M_ERASE: begin
                last_step = 3'd5;
                case (step)
                    3'd0, 3'd3: cmd_dat = 8'hAA;
                    3'd1, 3'd4: begin cmd_addr = 23'h555; cmd_dat = 8'h55; end
                    3'd2:       cmd_dat = 8'h80;
                    default:    cmd_dat = 8'h10;
                endcase
            end
            default: begin
                cmd_addr = addr;
                cmd_dat  = 8'hF0;
            end
        endcase
    end

    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode;
        addr_nxt     = addr;
        word_nxt     = word;
        idx_nxt      = idx;
        step_nxt     = step;
        cnt_nxt      = cnt;
        err_nxt      = err;
        bus_addr_nxt = bus_addr;
        bus_dat_nxt  = bus_dat;
        rdy          = 1'b0;
        ce_n         = 1'b1;
        we_n         = 1'b1;
        oe_n         = 1'b1;
        dq_oe        = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.iLOAD) begin
                    addr_nxt  = bus.iSTART_ADDR;
                    err_nxt   = 1'b0;
                    state_nxt = S_LOAD;
                end else if (bus.iCHIP_ERASE) begin
                    mode_nxt  = M_ERASE;
                    step_nxt  = 3'd0;
                    state_nxt = S_CMD;
                end else if (rst_done) begin
                    rdy = 1'b1;
                    if (bus.iVALID) begin
                        word_nxt  = bus.iDATA;
                        idx_nxt   = 2'd0;
                        step_nxt  = 3'd0;
                        mode_nxt  = M_PROG;
                        state_nxt = S_CMD;
                    end
                end
            end
            S_LOAD: state_nxt = S_IDLE;
            S_CMD: begin
                bus_addr_nxt = cmd_addr;
                bus_dat_nxt  = cmd_dat;
                cnt_nxt      = '0;
                state_nxt    = S_BUS_SETUP;
            end
            S_BUS_SETUP: begin
                ce_n      = 1'b0;
                dq_oe     = 1'b1;
                state_nxt = S_BUS_WE;
            end
            S_BUS_WE: begin
                ce_n  = 1'b0;
                dq_oe = 1'b1;
                we_n  = 1'b0;
                if (cnt == CNT_W'(WE_LOW_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_BUS_HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BUS_HOLD: begin
                ce_n  = 1'b0;
                dq_oe = 1'b1;
                if (step != last_step) begin
                    step_nxt  = step + 3'd1;
                    state_nxt = S_CMD;
                end else if (mode == M_RST) begin
                    state_nxt = S_ERROR;
                end else begin
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (cnt == CNT_W'(BUSY_DLY_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT_RDY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (bus.iRY) begin
                    cnt_nxt = '0;
                    if (mode == M_ERASE) begin
                        state_nxt = S_IDLE;
                    end else begin
`ifdef FLASH_PROG_VERIFY_EN
                        state_nxt = S_VERIFY;
`else
                        state_nxt = S_NEXT;
`endif
                    end
                end else if (mode == M_PROG) begin
                    // Erase may legitimately take seconds, so only programs time out.
                    if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_nxt   = 1'b1;
                        mode_nxt  = M_RST;
                        step_nxt  = 3'd0;
                        state_nxt = S_CMD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
`ifdef FLASH_PROG_VERIFY_EN
            S_VERIFY: begin
                ce_n = 1'b0;
                oe_n = 1'b0;
                if (cnt == CNT_W'(RD_CYC - 1)) begin
                    cnt_nxt = '0;
                    if (bus.iDQ != cur_byte) begin
                        err_nxt   = 1'b1;
                        mode_nxt  = M_RST;
                        step_nxt  = 3'd0;
                        state_nxt = S_CMD;
                    end else begin
                        state_nxt = S_NEXT;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            S_NEXT: begin
                addr_nxt = addr + 23'd1;
                idx_nxt  = idx + 2'd1;
                step_nxt = 3'd0;
                state_nxt = (idx == 2'd3) ? S_IDLE : S_CMD;
            end
            S_ERROR: begin
                if (bus.iLOAD) begin
                    addr_nxt  = bus.iSTART_ADDR;
                    err_nxt   = 1'b0;
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            state    <= S_IDLE;
            mode     <= M_PROG;
            addr     <= '0;
            word     <= '0;
            idx      <= '0;
            step     <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            bus_addr <= '0;
            bus_dat  <= '0;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode     <= mode_nxt;
            addr     <= addr_nxt;
            word     <= word_nxt;
            idx      <= idx_nxt;
            step     <= step_nxt;
            cnt      <= cnt_nxt;
            err      <= err_nxt;
            bus_addr <= bus_addr_nxt;
            bus_dat  <= bus_dat_nxt;
            rst_done <= 1'b1;
        end
    end

    assign bus.oREADY = rdy;
    assign bus.oBUSY  = (state != S_IDLE) && (state != S_ERROR);
    assign bus.oERR   = err;
    assign bus.oADDR  = bus_addr;
    assign bus.oDQ    = bus_dat;
    assign bus.oDQ_OE = dq_oe;
    assign bus.oCE_N  = ce_n;
    assign bus.oWE_N  = we_n;
    assign bus.oOE_N  = oe_n;

`ifndef FLASH_PROG_VERIFY_EN
    logic [7:0] unused_dq;
    assign unused_dq = bus.iDQ;
`endif
endmodule

// File: tb/tb_flash_programmer.sv
// Directed bench for flash_programmer: program, wrap, timeout, erase, reset abort, optional verify.
`timescale 1ns/1ps
module tb_flash_programmer;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #50 clk = ~clk;

    flash_programmer_if fif();
    flash_programmer dut (.iCLK(clk), .iRSTN(rstn), .bus(fif));

    typedef struct { logic [22:0] a; logic [7:0] d; int len; } wr_t;
    wr_t        wlog[$];
    int         oe_log[$];
    int         we_len = 0;
    int         oe_len = 0;
    logic [7:0] last_dat = 8'h00;
    logic       corrupt = 1'b0;
    int         vec = 0;
    int         miss = 0;

    logic [22:0] er_a [6] = '{23'hAAA, 23'h555, 23'hAAA, 23'hAAA, 23'h555, 23'hAAA};
    logic [7:0]  er_d [6] = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h10};
    logic [22:0] pc_a [3] = '{23'hAAA, 23'h555, 23'hAAA};
    logic [7:0]  pc_d [3] = '{8'hAA, 8'h55, 8'hA0};

`ifdef FLASH_PROG_VERIFY_EN
    localparam int WORD_CYC = 88;
`else
    localparam int WORD_CYC = 80;
`endif

    // Flash read model: returns the last byte written, optionally with bit 0 flipped.
    assign fif.iDQ = last_dat ^ {7'b0, corrupt};

    always @(negedge clk) begin
        if (fif.oWE_N === 1'b0) begin
            we_len = we_len + 1;
        end else if (we_len != 0) begin
            wlog.push_back('{fif.oADDR, fif.oDQ, we_len});
            last_dat = fif.oDQ;
            we_len = 0;
        end
        if (fif.oOE_N === 1'b0) begin
            oe_len = oe_len + 1;
        end else if (oe_len != 0) begin
            oe_log.push_back(oe_len);
            oe_len = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int max, output int n);
        n = 0;
        while (fif.oREADY !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(fif.oREADY), 32'd1);
    endtask

    task automatic do_load(input logic [22:0] a);
        fif.iSTART_ADDR = a;
        fif.iLOAD = 1'b1;
        tick();
        fif.iLOAD = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        fif.iDATA  = w;
        fif.iVALID = 1'b1;
        tick();
        fif.iVALID = 1'b0;
    endtask

    // Checks the three unlock writes preceding each of the four program writes.
    task automatic chk_unlocks(input string tag);
        int bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 4 != 3 && (wlog[k].a !== pc_a[k % 4] || wlog[k].d !== pc_d[k % 4])) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        fif.iSTART_ADDR = '0;
        fif.iLOAD = 1'b0;
        fif.iCHIP_ERASE = 1'b0;
        fif.iDATA = '0;
        fif.iVALID = 1'b0;
        fif.iRY = 1'b1;

        // Reset state
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_ce_n", 32'(fif.oCE_N), 32'd1);
        chk("rst_we_n", 32'(fif.oWE_N), 32'd1);
        chk("rst_oe_n", 32'(fif.oOE_N), 32'd1);
        chk("rst_ready", 32'(fif.oREADY), 32'd0);
        chk("rst_err", 32'(fif.oERR), 32'd0);
        chk("rst_busy", 32'(fif.oBUSY), 32'd0);
        chk("rst_addr", 32'(fif.oADDR), 32'd0);
        chk("rst_dq_oe", 32'(fif.oDQ_OE), 32'd0);
        rstn = 1'b1;
        tick();
        chk("rdy_after_rst", 32'(fif.oREADY), 32'd1);

        // Single word at 0x000100
        do_load(23'h000100);
        wait_ready("load_rdy", 10, n);
        chk("load_err", 32'(fif.oERR), 32'd0);
        wlog.delete();
        oe_log.delete();
        send_word(32'h44332211);
        chk("acc_busy", 32'(fif.oBUSY), 32'd1);
        chk("acc_ready", 32'(fif.oREADY), 32'd0);
        wait_ready("w1_done", 300, n);
        chk("w1_cycles", 32'(n), 32'(WORD_CYC));
        chk("w1_busy_end", 32'(fif.oBUSY), 32'd0);
        chk("w1_nwr", 32'(wlog.size()), 32'd16);
        if (wlog.size() == 16) begin
            chk_unlocks("w1_unlock");
            chk("w1_b0", {1'b0, wlog[3].a, wlog[3].d},   {1'b0, 23'h000100, 8'h11});
            chk("w1_b1", {1'b0, wlog[7].a, wlog[7].d},   {1'b0, 23'h000101, 8'h22});
            chk("w1_b2", {1'b0, wlog[11].a, wlog[11].d}, {1'b0, 23'h000102, 8'h33});
            chk("w1_b3", {1'b0, wlog[15].a, wlog[15].d}, {1'b0, 23'h000103, 8'h44});
            bad = 0;
            for (int k = 0; k < 16; k++) if (wlog[k].len != 1) bad++;
            chk("w1_we_len", 32'(bad), 32'd0);
        end
`ifdef FLASH_PROG_VERIFY_EN
        chk("vfy_nreads", 32'(oe_log.size()), 32'd4);
        bad = 0;
        foreach (oe_log[k]) if (oe_log[k] != 2) bad++;
        chk("vfy_oe_len", 32'(bad), 32'd0);
`endif

        // Address wrap
        do_load(23'h7FFFFE);
        wait_ready("wrap_load_rdy", 10, n);
        wlog.delete();
        send_word(32'hDDCCBBAA);
        wait_ready("wrap_done", 300, n);
        chk("wrap_nwr", 32'(wlog.size()), 32'd16);
        if (wlog.size() == 16) begin
            chk("wrap_b0", {1'b0, wlog[3].a, wlog[3].d},   {1'b0, 23'h7FFFFE, 8'hAA});
            chk("wrap_b1", {1'b0, wlog[7].a, wlog[7].d},   {1'b0, 23'h7FFFFF, 8'hBB});
            chk("wrap_b2", {1'b0, wlog[11].a, wlog[11].d}, {1'b0, 23'h000000, 8'hCC});
            chk("wrap_b3", {1'b0, wlog[15].a, wlog[15].d}, {1'b0, 23'h000001, 8'hDD});
        end

        // Load and valid together: load wins, no program starts
        wlog.delete();
        fif.iSTART_ADDR = 23'h000200;
        fif.iLOAD = 1'b1;
        fif.iDATA = 32'hCAFEF00D;
        fif.iVALID = 1'b1;
        #1;
        chk("ldvld_ready", 32'(fif.oREADY), 32'd0);
        tick();
        fif.iLOAD = 1'b0;
        fif.iVALID = 1'b0;
        wait_ready("ldvld_rdy", 10, n);
        chk("ldvld_nwr", 32'(wlog.size()), 32'd0);

        // Program timeout
        fif.iRY = 1'b0;
        wlog.delete();
        send_word(32'h12345678);
        n = 0;
        while (fif.oERR !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd4018);
        n = 0;
        while (fif.oBUSY !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("to_busy", 32'(fif.oBUSY), 32'd0);
        chk("to_nwr", 32'(wlog.size()), 32'd5);
        if (wlog.size() == 5) chk("to_reset_cmd", 32'(wlog[4].d), 32'hF0);
        fif.iDATA = 32'h0BADBEEF;
        fif.iVALID = 1'b1;
        repeat (3) tick();
        chk("err_ready", 32'(fif.oREADY), 32'd0);
        chk("err_busy", 32'(fif.oBUSY), 32'd0);
        chk("err_sticky", 32'(fif.oERR), 32'd1);
        fif.iVALID = 1'b0;
        fif.iCHIP_ERASE = 1'b1;
        tick();
        fif.iCHIP_ERASE = 1'b0;
        tick();
        chk("err_erase_ign", 32'(fif.oBUSY), 32'd0);
        chk("err_nwr", 32'(wlog.size()), 32'd5);
        fif.iRY = 1'b1;
        do_load(23'h000000);
        wait_ready("err_clr_rdy", 10, n);
        chk("err_clr", 32'(fif.oERR), 32'd0);

        // Chip erase with a long busy period
        wlog.delete();
        fif.iRY = 1'b0;
        fif.iCHIP_ERASE = 1'b1;
        tick();
        fif.iCHIP_ERASE = 1'b0;
        bad = 0;
        repeat (6000) begin
            tick();
            if (fif.oBUSY !== 1'b1 || fif.oERR !== 1'b0) bad++;
        end
        chk("er_hold_busy", 32'(bad), 32'd0);
        fif.iRY = 1'b1;
        wait_ready("er_done", 20, n);
        chk("er_nwr", 32'(wlog.size()), 32'd6);
        if (wlog.size() == 6) begin
            bad = 0;
            for (int k = 0; k < 6; k++) if (wlog[k].a !== er_a[k] || wlog[k].d !== er_d[k]) bad++;
            chk("er_seq", 32'(bad), 32'd0);
        end

        // Reset in the middle of a write
        send_word(32'hA5A5A5A5);
        tick();
        tick();
        chk("mid_we_low", 32'(fif.oWE_N), 32'd0);
        rstn = 1'b0;
        tick();
        chk("abort_we_n", 32'(fif.oWE_N), 32'd1);
        chk("abort_ce_n", 32'(fif.oCE_N), 32'd1);
        chk("abort_busy", 32'(fif.oBUSY), 32'd0);
        chk("abort_addr", 32'(fif.oADDR), 32'd0);
        chk("abort_ready", 32'(fif.oREADY), 32'd0);
        rstn = 1'b1;
        tick();
        chk("abort_rdy_after", 32'(fif.oREADY), 32'd1);

`ifdef FLASH_PROG_VERIFY_EN
        // Read-back mismatch on the first byte
        corrupt = 1'b1;
        do_load(23'h000100);
        wait_ready("vbad_load_rdy", 10, n);
        send_word(32'h44332211);
        n = 0;
        while (fif.oERR !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("vbad_cycles", 32'(n), 32'd21);
        chk("vbad_err", 32'(fif.oERR), 32'd1);
        corrupt = 1'b0;
        repeat (10) tick();
        do_load(23'h000000);
        wait_ready("vbad_clr_rdy", 10, n);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
